regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rf_read_port.sv | 52 +++++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear FSM encoding
// and default parameter values.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_NRD      = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address qualification, zero register,
// busy masking and optional write-first bypass with per-byte merge.
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    input  logic [DATA_W-1:0]     i_stored,
    input  logic                  i_busy,
    input  logic                  i_wr_ok,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wbe,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int NB = DATA_W / 8;

    logic              w_addr_ok;
    logic              w_hit;
    logic [DATA_W-1:0] w_merged;

    // Register 0 (when hardwired) and out-of-range addresses always read as zero.
    assign w_addr_ok = (int'(i_raddr) < DEPTH) &&
                       !((ZERO_REG != 0) && (i_raddr == '0));

    // i_wr_ok already implies idle and a writable address, so a hit is a real write.
    assign w_hit = (BYPASS != 0) && i_wr_ok && (i_waddr == i_raddr);

    // Byte-wise merge of the in-flight write over the stored word.
    always_comb begin
        w_merged = i_stored;
        for (int b = 0; b < NB; b++) begin
            if (i_wbe[b]) begin
                w_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
            end
        end
    end

    // Final read mux: disabled, busy or invalid addresses return zero.
    always_comb begin
        o_rdata = '0;
        if (i_re && !i_busy && w_addr_ok) begin
            o_rdata = w_hit ? w_merged : i_stored;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-strobed writes, NRD combinational read
// ports and a sequential bulk-clear engine that walks every register once.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  NRD      = DEF_NRD,
    parameter int  ZERO_REG = DEF_ZERO_REG,
    parameter int  BYPASS   = DEF_BYPASS,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [DATA_W/8-1:0]     wbe,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [NRD-1:0]          re,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    input  logic                    clr,
    output logic                    busy
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    logic              w_wr_ok;
    logic [DATA_W-1:0] w_stored [NRD];

    assign busy = r_busy;

    // A write is accepted only while idle and to an existing, writable register.
    assign w_wr_ok = we && (r_state == ST_IDLE) && (int'(waddr) < DEPTH) &&
                     !((ZERO_REG != 0) && (waddr == '0));

    // Storage updates and the clear FSM; a write coinciding with clr commits
    // first and is then wiped by the clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_ok) begin
                        for (int b = 0; b < NB; b++) begin
                            if (wbe[b]) begin
                                r_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                            end
                        end
                    end
                    if (clr) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_mem[r_cnt] <= '0;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Guarded array lookup per read port; out-of-range addresses yield zero.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            w_stored[k] = '0;
            if (int'(raddr[k*ADDR_W +: ADDR_W]) < DEPTH) begin
                w_stored[k] = r_mem[raddr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NRD; g++) begin : g_rd
            rf_read_port #(
                .DATA_W   (DATA_W),
                .DEPTH    (DEPTH),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_port (
                .i_re     (re[g]),
                .i_raddr  (raddr[g*ADDR_W +: ADDR_W]),
                .i_stored (w_stored[g]),
                .i_busy   (r_busy),
                .i_wr_ok  (w_wr_ok),
                .i_waddr  (waddr),
                .i_wdata  (wdata),
                .i_wbe    (wbe),
                .o_rdata  (rdata[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a write-through-storage instance and a
// bypass instance share every input.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [3:0]    wbe;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [1:0]    re;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata;
    logic [2*DW-1:0] rdata_bp;
    logic          clr;
    logic          busy;
    logic          busy_bp;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wbe   (wbe),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata),
        .clr   (clr),
        .busy  (busy)
    );

    regfile_mp #(.BYPASS(1)) dut_bp (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wbe   (wbe),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata_bp),
        .clr   (clr),
        .busy  (busy_bp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single write cycle; inputs change 1 time unit after the edge.
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
        @(posedge clk); #1;
        we = 1'b0; wbe = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        n_checks++;
        if (busy !== 1'b0 || busy_bp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b/%b want 0", busy, busy_bp);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        re = 2'b11;
        for (int a = 0; a < 32; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            n_checks++;
            if (rdata !== '0 || rdata_bp !== '0) begin
                n_fail++;
                $display("FAIL reset_read a=%0d: got %h/%h want 0", a, rdata, rdata_bp);
            end
        end
    endtask

    task automatic test_write_read();
        wr(5'd4, 32'hCCFFCCFF, 4'hF);
        wr(5'd31, 32'hFFFFFFFF, 4'hF);
        re = 2'b11; raddr = {5'd31, 5'd4}; #1;
        n_checks++;
        if (rdata !== {32'hFFFFFFFF, 32'hCCFFCCFF}) begin
            n_fail++;
            $display("FAIL wr_rd_both: got %h want ffffffffccffccff", rdata);
        end
        re = 2'b01; #1;
        n_checks++;
        if (rdata !== {32'h0, 32'hCCFFCCFF}) begin
            n_fail++;
            $display("FAIL wr_rd_re01: got %h want 00000000ccffccff", rdata);
        end
        re = 2'b10; #1;
        n_checks++;
        if (rdata !== {32'hFFFFFFFF, 32'h0}) begin
            n_fail++;
            $display("FAIL wr_rd_re10: got %h want ffffffff00000000", rdata);
        end
        re = 2'b00; #1;
        n_checks++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL wr_rd_re00: got %h want 0", rdata);
        end
    endtask

    task automatic test_zero_strobe();
        wr(5'd0, 32'hFFFF0000, 4'hF);
        re = 2'b11; raddr = {5'd0, 5'd0}; #1;
        n_checks++;
        if (rdata !== '0 || rdata_bp !== '0) begin
            n_fail++;
            $display("FAIL zero_reg: got %h/%h want 0", rdata, rdata_bp);
        end
        wr(5'd7, 32'hCCCCCCCC, 4'hF);
        wr(5'd7, 32'h11223344, 4'b0101);
        raddr = {5'd7, 5'd7}; #1;
        n_checks++;
        if (rdata !== {32'hCC22CC44, 32'hCC22CC44}) begin
            n_fail++;
            $display("FAIL byte_strobe_same_addr: got %h want cc22cc44cc22cc44", rdata);
        end
        wr(5'd7, 32'hAABBCCDD, 4'b1000);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL byte_strobe_top: got %h want aa22cc44", rdata[31:0]);
        end
        wr(5'd7, 32'h55555555, 4'b0000);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL byte_strobe_none: got %h want aa22cc44", rdata[31:0]);
        end
    endtask

    task automatic test_bypass();
        wr(5'd13, 32'h12345678, 4'hF);
        re = 2'b01; raddr = {5'd0, 5'd13};
        we = 1'b1; waddr = 5'd13; wdata = 32'h0000FFFF; wbe = 4'b0011;
        #1;
        n_checks++;
        if (rdata_bp[31:0] !== 32'h1234FFFF || rdata[31:0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_partial: got bp=%h nb=%h want 1234ffff/12345678", rdata_bp[31:0], rdata[31:0]);
        end
        wbe = 4'hF; #1;
        n_checks++;
        if (rdata_bp[31:0] !== 32'h0000FFFF || rdata[31:0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_full: got bp=%h nb=%h want 0000ffff/12345678", rdata_bp[31:0], rdata[31:0]);
        end
        raddr = {5'd0, 5'd4}; #1;
        n_checks++;
        if (rdata_bp[31:0] !== 32'hCCFFCCFF) begin
            n_fail++;
            $display("FAIL bypass_other_addr: got %h want ccffccff", rdata_bp[31:0]);
        end
        waddr = 5'd0; raddr = {5'd0, 5'd0}; #1;
        n_checks++;
        if (rdata_bp[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_zero_reg: got %h want 0", rdata_bp[31:0]);
        end
        waddr = 5'd13; raddr = {5'd0, 5'd13};
        @(posedge clk); #1;
        we = 1'b0; wbe = 4'h0; #1;
        n_checks++;
        if (rdata[31:0] !== 32'h0000FFFF || rdata_bp[31:0] !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL bypass_after_edge: got %h/%h want 0000ffff", rdata[31:0], rdata_bp[31:0]);
        end
    endtask

    task automatic test_clear();
        int cyc;
        for (int a = 1; a < 32; a++) begin
            wr(AW'(a), 32'h01010101 * a, 4'hF);
        end
        re = 2'b11; raddr = {5'd31, 5'd5}; #1;
        n_checks++;
        if (rdata !== {32'h1F1F1F1F, 32'h05050505}) begin
            n_fail++;
            $display("FAIL fill: got %h want 1f1f1f1f05050505", rdata);
        end
        we = 1'b1; waddr = 5'd5; wdata = 32'h88888888; wbe = 4'hF; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; waddr = 5'd9; wdata = 32'hDEADBEEF;
        raddr = {5'd9, 5'd5};
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (cyc == 3) clr = 1'b1;
            if (cyc == 4) clr = 1'b0;
            #1;
            n_checks++;
            if (rdata !== '0 || rdata_bp !== '0) begin
                n_fail++;
                $display("FAIL clear_busy_read cyc=%0d: got %h/%h want 0", cyc, rdata, rdata_bp);
            end
            cyc++;
            @(posedge clk); #1;
        end
        we = 1'b0; wbe = 4'h0;
        n_checks++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles want 32", cyc);
        end
        for (int a = 0; a < 32; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            n_checks++;
            if (rdata !== '0 || rdata_bp !== '0) begin
                n_fail++;
                $display("FAIL clear_after a=%0d: got %h/%h want 0", a, rdata, rdata_bp);
            end
        end
        wr(5'd9, 32'h0BADF00D, 4'hF);
        raddr = {5'd0, 5'd9}; #1;
        n_checks++;
        if (rdata[31:0] !== 32'h0BADF00D || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_then_write: got %h busy=%b want 0badf00d busy=0", rdata[31:0], busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        wr(5'd3, 32'h33333333, 4'hF);
        wr(5'd20, 32'h20202020, 4'hF);
        wr(5'd30, 32'h30303030, 4'hF);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclr_busy_pre: got %b want 1", busy);
        end
        rst_n = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0 || busy_bp !== 1'b0) begin
            n_fail++;
            $display("FAIL midclr_busy_async: got %b/%b want 0", busy, busy_bp);
        end
        #2; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midclr_idle: got busy=%b want 0", busy);
        end
        re = 2'b11;
        for (int a = 0; a < 32; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            n_checks++;
            if (rdata !== '0 || rdata_bp !== '0) begin
                n_fail++;
                $display("FAIL midclr_read a=%0d: got %h/%h want 0", a, rdata, rdata_bp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; we = 1'b0; wbe = 4'h0; waddr = '0; wdata = '0;
        re = 2'b00; raddr = '0; clr = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_zero_strobe();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
